// File: rtl/mem_load_sequencer_if.sv
// Bundle of pipeline, data-memory read and register-file write signals
// for the MEM-stage load sequencer.
interface mem_load_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [15:0]       EX_MEM_IR;
  logic [ADDR_W-1:0] EX_MEM_ADDR;
  logic [DATA_W-1:0] MEM_RD_DATA;
  logic              MEM_RD_EN;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              RF_WR_EN;
  logic [2:0]        RF_WR_ADDR;
  logic [DATA_W-1:0] RF_WR_DATA;
  logic              STALL;
  logic              BUSY;

  modport master (
    output EX_MEM_IR, EX_MEM_ADDR, MEM_RD_DATA,
    input  MEM_RD_EN, MEM_ADDR, RF_WR_EN, RF_WR_ADDR, RF_WR_DATA, STALL, BUSY
  );

  modport slave (
    input  EX_MEM_IR, EX_MEM_ADDR, MEM_RD_DATA,
    output MEM_RD_EN, MEM_ADDR, RF_WR_EN, RF_WR_ADDR, RF_WR_DATA, STALL, BUSY
  );
endinterface

// File: rtl/mem_load_sequencer.sv
// MEM-stage load controller: issues data-memory reads for LW and LM and
// returns the data as tagged register-file writes, stalling upstream during LM.
module mem_load_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  mem_load_sequencer_if.slave bus
);

  typedef enum logic {IDLE, LM_RUN} state_t;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_LM = 4'b0110;

  state_t            state, state_n;
  logic [7:0]        rem, rem_n;
  logic [ADDR_W-1:0] nxt, nxt_n;

  logic              rd_en_q, rd_en_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [2:0]        dest_q, dest_n;
  logic              stall_q, stall_n;
  logic              busy_q, busy_n;

  logic [RD_LAT-1:0]      tag_v;
  logic [RD_LAT-1:0][2:0] tag_d;
  logic                   wr_en_q;
  logic [2:0]             wr_addr_q;
  logic [DATA_W-1:0]      wr_data_q;

  logic [3:0] opcode;
  logic [7:0] src_mask;
  logic [2:0] pick;
  logic [7:0] src_clr;

  function automatic logic [2:0] top_bit(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // The same priority pick serves the first LM read (from the IR mask)
  // and every later one (from the remaining mask).
  assign opcode   = bus.EX_MEM_IR[15:12];
  assign src_mask = (state == LM_RUN) ? rem : bus.EX_MEM_IR[7:0];
  assign pick     = top_bit(src_mask);
  assign src_clr  = src_mask & ~(8'b1 << pick);

  always_comb begin
    state_n = state;
    rem_n   = rem;
    nxt_n   = nxt;
    rd_en_n = 1'b0;
    addr_n  = addr_q;
    dest_n  = dest_q;
    stall_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (opcode == OP_LW) begin
          rd_en_n = 1'b1;
          addr_n  = bus.EX_MEM_ADDR;
          dest_n  = bus.EX_MEM_IR[11:9];
        end else if (opcode == OP_LM && src_mask != 8'h00) begin
          rd_en_n = 1'b1;
          addr_n  = bus.EX_MEM_ADDR;
          dest_n  = 3'd7 - pick;
          rem_n   = src_clr;
          nxt_n   = bus.EX_MEM_ADDR + ADDR_W'(1);
          if (src_clr != 8'h00) begin
            state_n = LM_RUN;
            stall_n = 1'b1;
          end
        end
      end
      LM_RUN: begin
        rd_en_n = 1'b1;
        addr_n  = nxt;
        dest_n  = 3'd7 - pick;
        rem_n   = src_clr;
        nxt_n   = nxt + ADDR_W'(1);
        if (src_clr == 8'h00) state_n = IDLE;
        else                  stall_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // Reads are in flight until their write lands, so the tag pipe counts.
    busy_n = (state_n != IDLE) | rd_en_n | rd_en_q | (|tag_v);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem     <= '0;
      nxt     <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      dest_q  <= '0;
      stall_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      nxt     <= nxt_n;
      rd_en_q <= rd_en_n;
      addr_q  <= addr_n;
      dest_q  <= dest_n;
      stall_q <= stall_n;
      busy_q  <= busy_n;
    end
  end

  // Tag pipe stage 0 lines up with the cycle after MEM_RD_EN; the last stage
  // lines up with the cycle in which MEM_RD_DATA is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v     <= '0;
      tag_d     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      tag_v[0] <= rd_en_q;
      tag_d[0] <= dest_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_d[i] <= tag_d[i-1];
      end
      wr_en_q <= tag_v[RD_LAT-1];
      if (tag_v[RD_LAT-1]) begin
        wr_addr_q <= tag_d[RD_LAT-1];
        wr_data_q <= bus.MEM_RD_DATA;
      end
    end
  end

  assign bus.MEM_RD_EN  = rd_en_q;
  assign bus.MEM_ADDR   = addr_q;
  assign bus.RF_WR_EN   = wr_en_q;
  assign bus.RF_WR_ADDR = wr_addr_q;
  assign bus.RF_WR_DATA = wr_data_q;
  assign bus.STALL      = stall_q;
  assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Scoreboard bench for mem_load_sequencer: two instances (RD_LAT 1 and 3)
// share one directed instruction stream; a monitor checks reads, writes and latency.
module tb_mem_load_sequencer;

  localparam logic [15:0] NOP = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] ir_s;
  logic [15:0] addr_s;

  mem_load_sequencer_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
  mem_load_sequencer_if #(.DATA_W(16), .ADDR_W(16)) bus3 ();

  assign bus1.EX_MEM_IR   = ir_s;
  assign bus1.EX_MEM_ADDR = addr_s;
  assign bus3.EX_MEM_IR   = ir_s;
  assign bus3.EX_MEM_ADDR = addr_s;

  mem_load_sequencer #(.DATA_W(16), .ADDR_W(16), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_load_sequencer #(.DATA_W(16), .ADDR_W(16), .RD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return a ^ 16'hA5C3;
  endfunction

  // Data memory models: data valid RD_LAT cycles after the read strobe cycle.
  logic [15:0] m1, m3a, m3b, m3c;
  always @(posedge clk) begin
    m1  <= mem_val(bus1.MEM_ADDR);
    m3a <= mem_val(bus3.MEM_ADDR);
    m3b <= m3a;
    m3c <= m3b;
  end
  assign bus1.MEM_RD_DATA = m1;
  assign bus3.MEM_RD_DATA = m3c;

  logic [38:0] outs1, outs3;
  assign outs1 = {bus1.MEM_RD_EN, bus1.MEM_ADDR, bus1.RF_WR_EN, bus1.RF_WR_ADDR,
                  bus1.RF_WR_DATA, bus1.STALL, bus1.BUSY};
  assign outs3 = {bus3.MEM_RD_EN, bus3.MEM_ADDR, bus3.RF_WR_EN, bus3.RF_WR_ADDR,
                  bus3.RF_WR_DATA, bus3.STALL, bus3.BUSY};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stall_cnt [2];
  int s0, s1;
  logic chk_en;

  logic [15:0] rq [2][$];
  logic [18:0] wq [2][$];
  int          lq [2][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_rd(input logic [15:0] a);
    rq[0].push_back(a);
    rq[1].push_back(a);
  endtask

  task automatic exp_wr(input logic [2:0] d, input logic [15:0] v);
    wq[0].push_back({d, v});
    wq[1].push_back({d, v});
  endtask

  task automatic mon(input int id, input int lat, input logic rd, input logic [15:0] a,
                     input logic wr, input logic [2:0] wa, input logic [15:0] wd,
                     input logic st);
    logic [15:0] ea;
    logic [18:0] ew;
    int t;
    if (st) stall_cnt[id]++;
    if (rd) begin
      lq[id].push_back(cyc);
      if (rq[id].size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected dut%0d actual addr=%0h required no read", id, a);
      end else begin
        ea = rq[id].pop_front();
        chk($sformatf("rd_addr dut%0d", id), 64'(a), 64'(ea));
      end
    end
    if (wr) begin
      if (wq[id].size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected dut%0d actual R%0d=%0h required no write", id, wa, wd);
      end else begin
        ew = wq[id].pop_front();
        chk($sformatf("rf_write dut%0d", id), 64'({wa, wd}), 64'(ew));
      end
      if (lq[id].size() != 0) begin
        t = lq[id].pop_front();
        chk($sformatf("latency dut%0d", id), 64'(cyc - t), 64'(lat + 1));
      end
    end
  endtask

  task automatic issue(input logic [15:0] ir, input logic [15:0] a);
    int guard;
    guard = 0;
    @(negedge clk);
    ir_s   = ir;
    addr_s = a;
    while (bus1.STALL && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("stall_timeout", 64'(bus1.STALL), 64'd0);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ir_s   = NOP;
    addr_s = 16'h0000;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s0 = stall_cnt[0];
    s1 = stall_cnt[1];
  endtask

  task automatic stall_chk(input string nm, input int exp);
    chk({nm, " dut0"}, 64'(stall_cnt[0] - s0), 64'(exp));
    chk({nm, " dut1"}, 64'(stall_cnt[1] - s1), 64'(exp));
  endtask

  task automatic flush();
    for (int i = 0; i < 2; i++) begin
      rq[i].delete();
      wq[i].delete();
      lq[i].delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ir_s = NOP;
    addr_s = 16'h0000;
    chk_en = 1'b1;
    stall_cnt[0] = 0;
    stall_cnt[1] = 0;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
          mon(0, 1, bus1.MEM_RD_EN, bus1.MEM_ADDR, bus1.RF_WR_EN, bus1.RF_WR_ADDR,
              bus1.RF_WR_DATA, bus1.STALL);
          mon(1, 3, bus3.MEM_RD_EN, bus3.MEM_ADDR, bus3.RF_WR_EN, bus3.RF_WR_ADDR,
              bus3.RF_WR_DATA, bus3.STALL);
        end
        cyc++;
      end
    join_none

    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_outs dut0", 64'(outs1), 64'd0);
      chk("reset_outs dut1", 64'(outs3), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // LW with cycle-exact checks around the issue edge T.
    snap();
    exp_rd(16'h0010); exp_wr(3'd5, 16'hBEEF);
    issue(16'h4A05, 16'h0010);
    @(posedge clk); #1;
    chk("lw_rd_en_T", 64'(bus1.MEM_RD_EN), 64'd1);
    chk("lw_busy_T", 64'(bus1.BUSY), 64'd1);
    @(negedge clk); ir_s = NOP;
    @(posedge clk); #1;
    chk("lw_wr_en_T1", 64'(bus1.RF_WR_EN), 64'd0);
    @(posedge clk); #1;
    chk("lw_wr_T2", 64'({bus1.RF_WR_EN, bus1.RF_WR_ADDR, bus1.RF_WR_DATA}),
        64'({1'b1, 3'd5, 16'hBEEF}));
    chk("lw_busy_T2", 64'(bus1.BUSY), 64'd1);
    @(posedge clk); #1;
    chk("lw_busy_T3 dut0", 64'(bus1.BUSY), 64'd0);
    chk("lw_busy_T3 dut1", 64'(bus3.BUSY), 64'd1);
    @(posedge clk); #1;
    chk("lw_wr_T4 dut1", 64'(bus3.RF_WR_EN), 64'd1);
    @(posedge clk); #1;
    chk("lw_busy_T5 dut1", 64'(bus3.BUSY), 64'd0);
    idle(2);
    stall_chk("lw_stall", 0);

    // LM mask 1010_0101 from 0x0020.
    snap();
    exp_rd(16'h0020); exp_rd(16'h0021); exp_rd(16'h0022); exp_rd(16'h0023);
    exp_wr(3'd0, mem_val(16'h0020)); exp_wr(3'd2, mem_val(16'h0021));
    exp_wr(3'd5, mem_val(16'h0022)); exp_wr(3'd7, mem_val(16'h0023));
    issue(16'h60A5, 16'h0020);
    idle(10);
    stall_chk("lm_a5_stall", 3);

    // Empty mask, then single-bit mask.
    snap();
    issue(16'h6000, 16'h0030);
    exp_rd(16'h0040); exp_wr(3'd7, mem_val(16'h0040));
    issue(16'h6001, 16'h0040);
    idle(10);
    stall_chk("lm_00_01_stall", 0);

    // Full mask across the address wrap.
    snap();
    exp_rd(16'hFFFE); exp_rd(16'hFFFF);
    for (int i = 0; i < 6; i++) exp_rd(16'(i));
    exp_wr(3'd0, mem_val(16'hFFFE)); exp_wr(3'd1, mem_val(16'hFFFF));
    exp_wr(3'd2, mem_val(16'h0000)); exp_wr(3'd3, mem_val(16'h0001));
    exp_wr(3'd4, mem_val(16'h0002)); exp_wr(3'd5, mem_val(16'h0003));
    exp_wr(3'd6, mem_val(16'h0004)); exp_wr(3'd7, mem_val(16'h0005));
    issue(16'h60FF, 16'hFFFE);
    idle(12);
    stall_chk("lm_ff_stall", 7);

    // Interleave LW, LM(0x0C), SW, LW.
    snap();
    exp_rd(16'h0050); exp_wr(3'd1, mem_val(16'h0050));
    exp_rd(16'h0060); exp_rd(16'h0061);
    exp_wr(3'd4, mem_val(16'h0060)); exp_wr(3'd5, mem_val(16'h0061));
    exp_rd(16'h0080); exp_wr(3'd7, mem_val(16'h0080));
    issue(16'h4205, 16'h0050);
    issue(16'h600C, 16'h0060);
    issue(16'h5000, 16'h0070);
    issue(16'h4E00, 16'h0080);
    idle(10);
    stall_chk("mix_stall", 1);

    // Back-to-back LW.
    snap();
    exp_rd(16'h0090); exp_rd(16'h0091); exp_rd(16'h0092);
    exp_wr(3'd0, mem_val(16'h0090)); exp_wr(3'd1, mem_val(16'h0091));
    exp_wr(3'd2, mem_val(16'h0092));
    issue(16'h4000, 16'h0090);
    issue(16'h4200, 16'h0091);
    issue(16'h4400, 16'h0092);
    idle(10);
    stall_chk("b2b_stall", 0);
    chk("drained_busy dut0", 64'(bus1.BUSY), 64'd0);
    chk("drained_busy dut1", 64'(bus3.BUSY), 64'd0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rq_empty dut%0d", i), 64'(rq[i].size()), 64'd0);
      chk($sformatf("wq_empty dut%0d", i), 64'(wq[i].size()), 64'd0);
    end

    // Reset in the middle of a full-mask LM.
    chk_en = 1'b0;
    issue(16'h60FF, 16'h0100);
    @(posedge clk);
    @(negedge clk); ir_s = NOP;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("midlm_reset dut0", 64'(outs1), 64'd0);
      chk("midlm_reset dut1", 64'(outs3), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    flush();
    chk_en = 1'b1;
    idle(10);
    chk("post_reset_busy dut0", 64'(bus1.BUSY), 64'd0);
    chk("post_reset_busy dut1", 64'(bus3.BUSY), 64'd0);
    chk("post_reset_stall", 64'(bus1.STALL), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
